// File: rtl/keypad_entry.sv
// Keypad digit-entry front end: debounces scanner codes, builds a 4-digit entry and commits it on '#'.
// Optional auto-repeat of held digits is enabled by defining KEYPAD_ENTRY_AUTOREPEAT_EN.
module keypad_entry #(
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  key,
    output logic [15:0] entry,
    output logic [3:0]  show_mask,
    output logic [2:0]  count,
    output logic [15:0] value,
    output logic        value_valid,
    input  logic        value_ready,
    output logic        err
);

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] DEB_TGT  = 4'(DEBOUNCE);

    function automatic logic [3:0] mask_of(input logic [2:0] n);
        logic [3:0] m;
        case (n)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    logic [3:0] cand_r, deb_cnt_r, stable_r;
    logic [3:0] key_s, cand_s, cnt_s, stable_s;
    logic       press_s, event_s;

    // Next-state of the debouncer; codes C..E fold into "none"
    always_comb begin
        key_s    = (key <= 4'hB) ? key : KEY_NONE;
        cand_s   = cand_r;
        cnt_s    = deb_cnt_r;
        stable_s = stable_r;
        if (en) begin
            if (key_s == cand_r) begin
                cnt_s = (deb_cnt_r == 4'hF) ? 4'hF : deb_cnt_r + 4'd1;
            end else begin
                cand_s = key_s;
                cnt_s  = 4'd1;
            end
            if (cnt_s >= DEB_TGT) begin
                stable_s = cand_s;
            end else begin
                stable_s = stable_r;
            end
        end else begin
            stable_s = stable_r;
        end
        press_s = en && (stable_s != stable_r) && (stable_s != KEY_NONE);
    end

    // Debouncer state, advanced only on strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r    <= KEY_NONE;
            deb_cnt_r <= 4'd0;
            stable_r  <= KEY_NONE;
        end else begin
            cand_r    <= cand_s;
            deb_cnt_r <= cnt_s;
            stable_r  <= stable_s;
        end
    end

`ifdef KEYPAD_ENTRY_AUTOREPEAT_EN
    logic [7:0] rep_cnt_r;
    logic       rep_first_r;
    logic [7:0] rep_inc_s;
    logic       rep_fire_s;

    // Repeat fires only while the same digit stays stable across strobes
    always_comb begin
        rep_inc_s  = rep_cnt_r + 8'd1;
        rep_fire_s = 1'b0;
        if (en && !press_s && (stable_s == stable_r) && (stable_r <= 4'h9)) begin
            if (rep_first_r) begin
                rep_fire_s = (rep_inc_s == 8'(REPEAT_DELAY));
            end else begin
                rep_fire_s = (rep_inc_s == 8'(REPEAT_RATE));
            end
        end else begin
            rep_fire_s = 1'b0;
        end
        event_s = press_s || rep_fire_s;
    end

    // Repeat timer: restarts on each press, frozen while en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r   <= 8'd0;
            rep_first_r <= 1'b0;
        end else if (press_s) begin
            rep_cnt_r   <= 8'd0;
            rep_first_r <= 1'b1;
        end else if (en) begin
            if ((stable_s != stable_r) || (stable_r > 4'h9) || rep_fire_s) begin
                rep_cnt_r   <= 8'd0;
                rep_first_r <= 1'b0;
            end else begin
                rep_cnt_r   <= rep_inc_s;
                rep_first_r <= rep_first_r;
            end
        end else begin
            rep_cnt_r   <= rep_cnt_r;
            rep_first_r <= rep_first_r;
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

    // One event per press when auto-repeat is compiled out
    always_comb begin
        event_s = press_s;
    end
`endif

    // Entry editing, commit and consumer handshake (handshake runs every clk)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry       <= 16'h0000;
            count       <= 3'd0;
            show_mask   <= 4'b0000;
            value       <= 16'h0000;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (value_valid && value_ready) begin
                value_valid <= 1'b0;
            end else begin
                value_valid <= value_valid;
            end
            if (event_s) begin
                if (stable_s <= 4'h9) begin
                    if (count != 3'd4) begin
                        entry     <= {entry[11:0], stable_s};
                        count     <= count + 3'd1;
                        show_mask <= mask_of(count + 3'd1);
                    end else begin
                        err <= 1'b1;
                    end
                end else if (stable_s == KEY_STAR) begin
                    if (count != 3'd0) begin
                        entry     <= {4'h0, entry[15:4]};
                        count     <= count - 3'd1;
                        show_mask <= mask_of(count - 3'd1);
                    end else begin
                        err <= 1'b1;
                    end
                end else if (stable_s == KEY_HASH) begin
                    // A pending value blocks commit even if it is being accepted this clk
                    if ((count != 3'd0) && !value_valid) begin
                        value       <= entry;
                        value_valid <= 1'b1;
                        entry       <= 16'h0000;
                        count       <= 3'd0;
                        show_mask   <= 4'b0000;
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    err <= 1'b0;
                end
            end else begin
                entry <= entry;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: stimulus queues expected output snapshots, a negedge monitor checks them.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  key = 4'hF;
    logic        value_ready = 1'b0;
    logic [15:0] entry, value;
    logic [3:0]  show_mask;
    logic [2:0]  count;
    logic        value_valid, err;

    keypad_entry dut (
        .clk(clk), .rst_n(rst_n), .en(en), .key(key),
        .entry(entry), .show_mask(show_mask), .count(count),
        .value(value), .value_valid(value_valid), .value_ready(value_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] entry;
        logic [2:0]  count;
        logic [3:0]  mask;
        logic [15:0] value;
        logic        valid;
        int          errs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   exp_errs = 0;

    // Monitor: counts err pulses and compares any pending expectation
    always @(negedge clk) begin
        if (err === 1'b1) err_seen++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (entry !== mon_e.entry || count !== mon_e.count || show_mask !== mon_e.mask ||
                value !== mon_e.value || value_valid !== mon_e.valid || err_seen != mon_e.errs) begin
                errors++;
                $display("FAIL %s: got entry=%h count=%0d mask=%b value=%h valid=%b errs=%0d, expected entry=%h count=%0d mask=%b value=%h valid=%b errs=%0d",
                         mon_e.name, entry, count, show_mask, value, value_valid, err_seen,
                         mon_e.entry, mon_e.count, mon_e.mask, mon_e.value, mon_e.valid, mon_e.errs);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_n(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            key = k;
            en  = 1'b1;
            tick();
        end
        en = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        strobe_n(k, 3);
        strobe_n(4'hF, 3);
    endtask

    task automatic expect_state(input string name, input logic [15:0] e_entry, input logic [2:0] e_count,
                                input logic [3:0] e_mask, input logic [15:0] e_value, input logic e_valid);
        exp_t e;
        e.name = name; e.entry = e_entry; e.count = e_count; e.mask = e_mask;
        e.value = e_value; e.valid = e_valid; e.errs = exp_errs;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        expect_state("reset", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        tick();

        // Two-digit entry with a short release between keys
        strobe_n(4'h1, 2);
        expect_state("debounce_incomplete", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);
        strobe_n(4'h1, 1);
        expect_state("first_digit", 16'h0001, 3'd1, 4'b0001, 16'h0000, 1'b0);
        strobe_n(4'hF, 1);
        strobe_n(4'h2, 3);
        expect_state("two_digits", 16'h0012, 3'd2, 4'b0011, 16'h0000, 1'b0);
        strobe_n(4'hF, 3);

        do_reset();
        for (int i = 0; i < 10; i++) strobe_n((i % 2 == 0) ? 4'h5 : 4'hF, 1);
        expect_state("bounce_no_event", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);

        // Overflow and backspace
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        expect_state("four_digits", 16'h1234, 3'd4, 4'b1111, 16'h0000, 1'b0);
        press(4'h5); exp_errs++;
        expect_state("fifth_digit_err", 16'h1234, 3'd4, 4'b1111, 16'h0000, 1'b0);
        press(4'hA);
        expect_state("backspace", 16'h0123, 3'd3, 4'b0111, 16'h0000, 1'b0);
        press(4'hA); press(4'hA); press(4'hA);
        expect_state("backspace_to_empty", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);
        press(4'hA); exp_errs++;
        expect_state("backspace_empty_err", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);

        // Commit and handshake
        press(4'hB); exp_errs++;
        expect_state("hash_empty_err", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);
        press(4'h4); press(4'h2);
        expect_state("entry_42", 16'h0042, 3'd2, 4'b0011, 16'h0000, 1'b0);
        press(4'hB);
        expect_state("commit_42", 16'h0000, 3'd0, 4'b0000, 16'h0042, 1'b1);
        press(4'h7); press(4'hB); exp_errs++;
        expect_state("hash_pending_err", 16'h0007, 3'd1, 4'b0001, 16'h0042, 1'b1);
        strobe_n(4'hB, 2);
        value_ready = 1'b1;
        strobe_n(4'hB, 1);
        value_ready = 1'b0;
        exp_errs++;
        expect_state("hash_during_accept", 16'h0007, 3'd1, 4'b0001, 16'h0042, 1'b0);
        strobe_n(4'hF, 3);
        press(4'hB);
        expect_state("commit_7", 16'h0000, 3'd0, 4'b0000, 16'h0007, 1'b1);
        value_ready = 1'b1;
        tick();
        value_ready = 1'b0;
        expect_state("accept_without_en", 16'h0000, 3'd0, 4'b0000, 16'h0007, 1'b0);

        // Asynchronous reset mid-entry with a pending value
        press(4'h1); press(4'h2); press(4'h3); press(4'hB);
        press(4'h4); press(4'h5); press(4'h6);
        expect_state("pre_reset", 16'h0456, 3'd3, 4'b0111, 16'h0123, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        begin
            exp_t e;
            e.name = "async_reset"; e.entry = 16'h0000; e.count = 3'd0; e.mask = 4'b0000;
            e.value = 16'h0000; e.valid = 1'b0; e.errs = exp_errs;
            exp_q.push_back(e);
        end
        #5;
        rst_n = 1'b1;
        strobe_n(4'h9, 2);
        tick(); tick(); tick();
        expect_state("post_reset_short", 16'h0000, 3'd0, 4'b0000, 16'h0000, 1'b0);
        strobe_n(4'h9, 1);
        expect_state("post_reset_full", 16'h0009, 3'd1, 4'b0001, 16'h0000, 1'b0);
        strobe_n(4'hF, 3);

        // Held digit: repeats only when auto-repeat is compiled in
        do_reset();
`ifdef KEYPAD_ENTRY_AUTOREPEAT_EN
        strobe_n(4'h7, 11);
        expect_state("repeat_first", 16'h0077, 3'd2, 4'b0011, 16'h0000, 1'b0);
        strobe_n(4'h7, 7);
        expect_state("repeat_second", 16'h0777, 3'd3, 4'b0111, 16'h0000, 1'b0);
        strobe_n(4'h7, 2);
        expect_state("repeat_third", 16'h7777, 3'd4, 4'b1111, 16'h0000, 1'b0);
`else
        strobe_n(4'h7, 22);
        expect_state("held_single_event", 16'h0007, 3'd1, 4'b0001, 16'h0000, 1'b0);
`endif
        strobe_n(4'hF, 3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 3: consecutive identical en-strobe samples that make a key code stable, range 1..15.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 8: en-strobes a digit is held before its first auto-repeat (used only with KEYPAD_ENTRY_AUTOREPEAT_EN).
REQ-003 The block SHALL have parameter REPEAT_RATE, default 4: en-strobes between later auto-repeats (used only with KEYPAD_ENTRY_AUTOREPEAT_EN).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  sample strobe; key handling advances only on cycles with en=1.
REQ-007 key  in  4  code from the keypad scanner: 0-9 digit, 4'hA '*', 4'hB '#', 4'hF none, 4'hC-4'hE treated as none.
REQ-008 entry  out  16  digits being typed, newest digit in [3:0], for the display hexx input.
REQ-009 show_mask  out  4  bit i=1 when i < count, for the display digit-enable input.
REQ-010 count  out  3  number of digits typed, 0..4.
REQ-011 value  out  16  committed number, held stable while value_valid=1.
REQ-012 value_valid  out  1  committed value available.
REQ-013 value_ready  in  1  consumer accepts value when value_valid=1.
REQ-014 err  out  1  one-clock pulse when a key event is rejected.

Function
REQ-015 Debounce SHALL work as follows: on each strobe, key equal to the candidate increments a saturating counter, otherwise the candidate loads key and the counter loads 1; the counter reaching DEBOUNCE sets stable_key to the candidate.
REQ-016 A key event SHALL fire on the strobe where stable_key changes to a value other than none; a direct change from one key to another fires, and a release to none fires nothing.
REQ-017 A digit event with count<4 SHALL set entry to {entry[11:0],digit} and increment count.
REQ-018 A digit event with count=4 SHALL leave entry and count unchanged and pulse err.
REQ-019 A '*' event with count>0 SHALL act as backspace: entry becomes {4'h0,entry[15:4]} and count decrements; with count=0 it SHALL pulse err.
REQ-020 A '#' event with count>0 and value_valid=0 SHALL load value from entry, set value_valid, and clear entry and count.
REQ-021 A '#' event with count=0 or value_valid=1 SHALL change nothing and pulse err; this includes the cycle where value_ready=1.
REQ-022 value_valid SHALL clear on the clock after value_valid&&value_ready, and value SHALL hold until the next commit.
REQ-023 Latency: entry, count, value, value_valid and err SHALL update on the clk edge ending the strobe cycle whose debounce completes, so they are visible one clk later.
REQ-024 Handshake logic SHALL run every clk whatever the state of en.
REQ-025 With en=0, debounce state, stable_key and repeat timers SHALL hold.

Reset
REQ-026 While rst_n=0, regardless of clk, the block SHALL hold candidate=4'hF, debounce counter=0, stable_key=4'hF, entry=0, count=0, show_mask=0, value=0, value_valid=0, err=0 and repeat timers=0.
REQ-027 Reset asserted mid-entry or with value pending SHALL discard everything, and the first event after release SHALL require a full DEBOUNCE sequence.

Configuration
REQ-028 With KEYPAD_ENTRY_AUTOREPEAT_EN defined, a digit stable for REPEAT_DELAY further strobes after its event SHALL issue a repeat digit event, then one every REPEAT_RATE strobes until stable_key changes; '*' and '#' SHALL never repeat.
REQ-029 Without KEYPAD_ENTRY_AUTOREPEAT_EN, each press SHALL produce exactly one event, and the repeat logic and the REPEAT_DELAY and REPEAT_RATE parameters SHALL have no effect.

Verification
REQ-030 Key 4'h1 held 3 strobes, then 4'hF, then key 4'h2 held 3 strobes -> entry=16'h0012, count=2, show_mask=4'b0011.
REQ-031 Key 4'h5 toggling 4'h5/4'hF every strobe for 10 strobes -> no event, entry=0, err never asserted.
REQ-032 Digits 1,2,3,4,5 entered -> entry=16'h1234, count=4, single err pulse on the fifth; then '*' -> entry=16'h0123, count=3.
REQ-033 Entry 16'h0042 then '#' with value_ready=0 -> value=16'h0042, value_valid=1, entry=0; a second '#' after typing 7 -> err pulse, value unchanged; value_ready=1 for 1 clk -> value_valid=0 on the next clk.
REQ-034 rst_n pulsed low between clk edges with count=3 and value_valid=1 -> all outputs 0 immediately; key 4'h9 held 2 strobes after release -> no event.
REQ-035 With KEYPAD_ENTRY_AUTOREPEAT_EN and defaults, key 4'h7 held 20 strobes after stable -> entry=16'h7777, count=4, events at stable+0, +8, +12, +16.
